// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU arbiter slice.
//   - state_e   : arbiter FSM state encoding
//   - FLAG_*    : bit positions of the flags inside resp_flags ({C,N,P,Z})
//   - MAX_WIDTH_DEF : default operand/result width
//   - pack_flags: assembles the four ALU flags into the resp_flags layout
package alu_pkg;

  localparam int MAX_WIDTH_DEF = 8;

  localparam int FLAG_C = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_P = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_CAPT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  function automatic logic [3:0] pack_flags(input logic c, input logic n,
                                            input logic p, input logic z);
    logic [3:0] f;
    f         = 4'b0000;
    f[FLAG_C] = c;
    f[FLAG_N] = n;
    f[FLAG_P] = p;
    f[FLAG_Z] = z;
    return f;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant, purely combinational.
//   valid0/valid1 : requests
//   last          : requester granted most recently (0 or 1)
//   grant0/grant1 : one-hot (or zero) grant
// A lone request always wins; on a tie the requester that was not granted
// last wins.
module rr_arbiter2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last,
  output logic grant0,
  output logic grant1
);

  // Grant selection: lone requester wins, tie goes to the one not served last.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (valid0 && valid1) begin
      grant0 = last;
      grant1 = ~last;
    end else if (valid0) begin
      grant0 = 1'b1;
    end else if (valid1) begin
      grant1 = 1'b1;
    end else begin
      grant0 = 1'b0;
      grant1 = 1'b0;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between two requesters, one operation in flight.
//   clk, rst (sync, active-low)
//   reqN_valid/reqN_ready + reqN_selop/shamt/a/b : requester N (N=0,1)
//   alu_enaf, alu_selop/shamt/busA/busB          : registered ALU drive
//   alu_busC, alu_C/N/P/Z                        : ALU result and flags
//   resp_valid/resp_ready, resp_id/data/flags    : result channel
//   busy, ops_done                               : status
// Flow: IDLE --accept--> EXEC (enaf=1) --> CAPT (capture result) --> RESP
// --handshake--> IDLE.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int MAX_WIDTH = MAX_WIDTH_DEF,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [2:0]           req0_selop,
  input  logic [1:0]           req0_shamt,
  input  logic [MAX_WIDTH-1:0] req0_a,
  input  logic [MAX_WIDTH-1:0] req0_b,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [2:0]           req1_selop,
  input  logic [1:0]           req1_shamt,
  input  logic [MAX_WIDTH-1:0] req1_a,
  input  logic [MAX_WIDTH-1:0] req1_b,
  output logic                 alu_enaf,
  output logic [2:0]           alu_selop,
  output logic [1:0]           alu_shamt,
  output logic [MAX_WIDTH-1:0] alu_busA,
  output logic [MAX_WIDTH-1:0] alu_busB,
  input  logic [MAX_WIDTH-1:0] alu_busC,
  input  logic                 alu_C,
  input  logic                 alu_N,
  input  logic                 alu_P,
  input  logic                 alu_Z,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 resp_id,
  output logic [MAX_WIDTH-1:0] resp_data,
  output logic [3:0]           resp_flags,
  output logic                 busy,
  output logic [CNT_W-1:0]     ops_done
);

  state_e               state_q, state_d;
  logic                 last_q, last_d;
  logic [2:0]           selop_q, selop_d;
  logic [1:0]           shamt_q, shamt_d;
  logic [MAX_WIDTH-1:0] a_q, a_d;
  logic [MAX_WIDTH-1:0] b_q, b_d;
  logic                 enaf_q, enaf_d;
  logic                 rvalid_q, rvalid_d;
  logic                 id_q, id_d;
  logic [MAX_WIDTH-1:0] data_q, data_d;
  logic [3:0]           flags_q, flags_d;
  logic [CNT_W-1:0]     ops_q, ops_d;

  logic grant0_s, grant1_s;
  logic accept0_s, accept1_s;

  rr_arbiter2 u_rr (
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .last   (last_q),
    .grant0 (grant0_s),
    .grant1 (grant1_s)
  );

  // Ready is offered only in IDLE and never while reset is being applied.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (rst && (state_q == ST_IDLE)) begin
      req0_ready = grant0_s;
      req1_ready = grant1_s;
    end else begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
    end
  end

  assign accept0_s = req0_valid & req0_ready;
  assign accept1_s = req1_valid & req1_ready;

  // Next-state and next-register computation for the operation FSM.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    selop_d = selop_q;
    shamt_d = shamt_q;
    a_d     = a_q;
    b_d     = b_q;
    id_d    = id_q;
    data_d  = data_q;
    flags_d = flags_q;
    ops_d   = ops_q;
    case (state_q)
      ST_IDLE: begin
        if (accept0_s) begin
          state_d = ST_EXEC;
          selop_d = req0_selop;
          shamt_d = req0_shamt;
          a_d     = req0_a;
          b_d     = req0_b;
          id_d    = 1'b0;
          last_d  = 1'b0;
        end else if (accept1_s) begin
          state_d = ST_EXEC;
          selop_d = req1_selop;
          shamt_d = req1_shamt;
          a_d     = req1_a;
          b_d     = req1_b;
          id_d    = 1'b1;
          last_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        state_d = ST_CAPT;
      end
      ST_CAPT: begin
        // ALU flags were latched by the ALU at the end of EXEC.
        state_d = ST_RESP;
        data_d  = alu_busC;
        flags_d = pack_flags(alu_C, alu_N, alu_P, alu_Z);
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
          ops_d   = ops_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    enaf_d   = (state_d == ST_EXEC);
    rvalid_d = (state_d == ST_RESP);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      last_q   <= 1'b1;
      selop_q  <= 3'b000;
      shamt_q  <= 2'b00;
      a_q      <= {MAX_WIDTH{1'b0}};
      b_q      <= {MAX_WIDTH{1'b0}};
      enaf_q   <= 1'b0;
      rvalid_q <= 1'b0;
      id_q     <= 1'b0;
      data_q   <= {MAX_WIDTH{1'b0}};
      flags_q  <= 4'b0000;
      ops_q    <= {CNT_W{1'b0}};
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      selop_q  <= selop_d;
      shamt_q  <= shamt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      enaf_q   <= enaf_d;
      rvalid_q <= rvalid_d;
      id_q     <= id_d;
      data_q   <= data_d;
      flags_q  <= flags_d;
      ops_q    <= ops_d;
    end
  end

  assign alu_enaf   = enaf_q;
  assign alu_selop  = selop_q;
  assign alu_shamt  = shamt_q;
  assign alu_busA   = a_q;
  assign alu_busB   = b_q;
  assign resp_valid = rvalid_q;
  assign resp_id    = id_q;
  assign resp_data  = data_q;
  assign resp_flags = flags_q;
  assign busy       = (state_q != ST_IDLE);
  assign ops_done   = ops_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: self-checking bench for alu_arbiter with an adder stub ALU.
// A second instance with CNT_W=2 sees identical stimulus to check counter wrap.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [2:0] req0_selop = 3'b000, req1_selop = 3'b000;
  logic [1:0] req0_shamt = 2'b00, req1_shamt = 2'b00;
  logic [7:0] req0_a = 8'h00, req0_b = 8'h00, req1_a = 8'h00, req1_b = 8'h00;
  logic       resp_ready = 1'b0;

  logic       req0_ready, req1_ready, alu_enaf, resp_valid, resp_id, busy;
  logic [2:0] alu_selop;
  logic [1:0] alu_shamt;
  logic [7:0] alu_busA, alu_busB, alu_busC, resp_data;
  logic [3:0] resp_flags;
  logic [15:0] ops_done;
  logic       alu_C = 1'b0, alu_N = 1'b0, alu_P = 1'b0, alu_Z = 1'b0;

  logic       w_r0, w_r1, w_enaf, w_rv, w_id, w_busy;
  logic [2:0] w_selop;
  logic [1:0] w_shamt;
  logic [7:0] w_busA, w_busB, w_busC, w_data;
  logic [3:0] w_flags;
  logic [1:0] w_ops;
  logic       w_C = 1'b0, w_N = 1'b0, w_P = 1'b0, w_Z = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.MAX_WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_selop(req0_selop),
    .req0_shamt(req0_shamt), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_selop(req1_selop),
    .req1_shamt(req1_shamt), .req1_a(req1_a), .req1_b(req1_b),
    .alu_enaf(alu_enaf), .alu_selop(alu_selop), .alu_shamt(alu_shamt),
    .alu_busA(alu_busA), .alu_busB(alu_busB), .alu_busC(alu_busC),
    .alu_C(alu_C), .alu_N(alu_N), .alu_P(alu_P), .alu_Z(alu_Z),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_flags(resp_flags), .busy(busy), .ops_done(ops_done)
  );

  alu_arbiter #(.MAX_WIDTH(8), .CNT_W(2)) dut_w (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(w_r0), .req0_selop(req0_selop),
    .req0_shamt(req0_shamt), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(w_r1), .req1_selop(req1_selop),
    .req1_shamt(req1_shamt), .req1_a(req1_a), .req1_b(req1_b),
    .alu_enaf(w_enaf), .alu_selop(w_selop), .alu_shamt(w_shamt),
    .alu_busA(w_busA), .alu_busB(w_busB), .alu_busC(w_busC),
    .alu_C(w_C), .alu_N(w_N), .alu_P(w_P), .alu_Z(w_Z),
    .resp_valid(w_rv), .resp_ready(resp_ready), .resp_id(w_id),
    .resp_data(w_data), .resp_flags(w_flags), .busy(w_busy), .ops_done(w_ops)
  );

  // Stub ALUs: combinational sum, flags latched when enaf is high.
  logic [8:0] sum_s, sum_w;
  assign sum_s    = {1'b0, alu_busA} + {1'b0, alu_busB};
  assign alu_busC = sum_s[7:0];
  assign sum_w    = {1'b0, w_busA} + {1'b0, w_busB};
  assign w_busC   = sum_w[7:0];
  always @(posedge clk) begin
    if (alu_enaf) begin
      alu_C <= sum_s[8]; alu_N <= sum_s[7];
      alu_Z <= (sum_s[7:0] == 8'h00); alu_P <= ~sum_s[7] & (sum_s[7:0] != 8'h00);
    end
    if (w_enaf) begin
      w_C <= sum_w[8]; w_N <= sum_w[7];
      w_Z <= (sum_w[7:0] == 8'h00); w_P <= ~sum_w[7] & (sum_w[7:0] != 8'h00);
    end
  end

  // Reference model state
  int mdl_last = 1;
  int mdl_ops  = 0;

  function automatic int pick(input bit v0, input bit v1, input int last);
    if (v0 && v1) return 1 - last;
    else if (v0)  return 0;
    else          return 1;
  endfunction

  function automatic logic [7:0] mdl_sum(input int a, input int b);
    return 8'((a + b) % 256);
  endfunction

  function automatic logic [3:0] mdl_flags(input int a, input int b);
    int s; bit c, n, p, z;
    s = a + b;
    c = (s > 255);
    n = ((s % 256) >= 128);
    z = ((s % 256) == 0);
    p = !n && !z;
    return {c, n, p, z};
  endfunction

  // Observations from the last run_op
  logic       obs_rdy0, obs_rdy1, obs_en_exec, obs_en_capt, obs_en_resp;
  logic       obs_rv_exec, obs_rv_capt, obs_rv_resp, obs_id, obs_rv_after;
  logic       obs_busy_after, obs_busy_after2, obs_hold_ok;
  logic [2:0] obs_selop;
  logic [7:0] obs_busA, obs_busB, obs_data;
  logic [3:0] obs_flags;
  logic [15:0] obs_ops;
  logic [1:0] obs_ops2;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    mdl_last = 1; mdl_ops = 0;
  endtask

  // Drives one operation from IDLE through handshake; records observations.
  task automatic run_op(input bit v0, input bit v1, input logic [2:0] s0, input logic [2:0] s1,
                        input logic [7:0] a0, input logic [7:0] b0,
                        input logic [7:0] a1, input logic [7:0] b1, input int hold);
    req0_valid = v0; req1_valid = v1;
    req0_selop = s0; req1_selop = s1;
    req0_shamt = 2'($urandom_range(0, 3)); req1_shamt = 2'($urandom_range(0, 3));
    req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
    resp_ready = 1'b1;
    @(negedge clk);
    obs_rdy0 = req0_ready; obs_rdy1 = req1_ready;
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    obs_en_exec = alu_enaf; obs_rv_exec = resp_valid;
    obs_selop = alu_selop; obs_busA = alu_busA; obs_busB = alu_busB;
    step();
    obs_en_capt = alu_enaf; obs_rv_capt = resp_valid;
    step();
    resp_ready = 1'b0;
    obs_rv_resp = resp_valid; obs_en_resp = alu_enaf;
    obs_id = resp_id; obs_data = resp_data; obs_flags = resp_flags;
    obs_hold_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_a = 8'($urandom_range(0, 255)); req1_b = 8'($urandom_range(0, 255));
      @(negedge clk);
      if (req0_ready || req1_ready) obs_hold_ok = 1'b0;
      step();
      if (resp_valid !== 1'b1 || resp_data !== obs_data || resp_id !== obs_id ||
          resp_flags !== obs_flags || alu_busA !== obs_busA || busy !== 1'b1)
        obs_hold_ok = 1'b0;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    obs_rv_after = resp_valid; obs_busy_after = busy;
    obs_ops = ops_done; obs_ops2 = w_ops;
    step();
    obs_busy_after2 = busy;
  endtask

  task automatic test_reset();
    rst = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
    step(); step();
    @(negedge clk);
    n_checks++; if ({req0_ready, req1_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready got=%b exp=00", {req0_ready, req1_ready}); end
    n_checks++; if ({resp_valid, busy, alu_enaf, resp_id} !== 4'b0000) begin n_fail++; $display("FAIL reset_ctrl got=%b exp=0000", {resp_valid, busy, alu_enaf, resp_id}); end
    n_checks++; if ({alu_busA, alu_busB, resp_data, resp_flags, alu_selop} !== 31'd0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", {alu_busA, alu_busB, resp_data, resp_flags, alu_selop}); end
    n_checks++; if (ops_done !== 16'd0) begin n_fail++; $display("FAIL reset_ops got=%0d exp=0", ops_done); end
    req0_valid = 1'b0; req1_valid = 1'b0; rst = 1'b1;
    step();
    mdl_last = 1; mdl_ops = 0;
  endtask

  task automatic test_single();
    run_op(1'b1, 1'b0, 3'b101, 3'b000, 8'h26, 8'h10, 8'h00, 8'h00, 0);
    mdl_last = 0; mdl_ops++;
    n_checks++; if ({obs_rdy0, obs_rdy1} !== 2'b10) begin n_fail++; $display("FAIL single_ready got=%b exp=10", {obs_rdy0, obs_rdy1}); end
    n_checks++; if ({obs_en_exec, obs_en_capt, obs_en_resp} !== 3'b100) begin n_fail++; $display("FAIL single_enaf got=%b exp=100", {obs_en_exec, obs_en_capt, obs_en_resp}); end
    n_checks++; if ({obs_rv_exec, obs_rv_capt, obs_rv_resp} !== 3'b001) begin n_fail++; $display("FAIL single_latency got=%b exp=001", {obs_rv_exec, obs_rv_capt, obs_rv_resp}); end
    n_checks++; if (obs_selop !== 3'b101 || obs_busA !== 8'h26 || obs_busB !== 8'h10) begin n_fail++; $display("FAIL single_operands got=%b/%h/%h exp=101/26/10", obs_selop, obs_busA, obs_busB); end
    n_checks++; if (obs_id !== 1'b0 || obs_data !== 8'h36) begin n_fail++; $display("FAIL single_resp got=%b/%h exp=0/36", obs_id, obs_data); end
    n_checks++; if (obs_ops !== 16'd1) begin n_fail++; $display("FAIL single_ops got=%0d exp=1", obs_ops); end
    n_checks++; if (obs_rv_after !== 1'b0 || obs_busy_after !== 1'b0) begin n_fail++; $display("FAIL single_idle got=%b%b exp=00", obs_rv_after, obs_busy_after); end
  endtask

  task automatic test_contention();
    logic [7:0] a0, b0, a1, b1;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      a0 = 8'($urandom_range(0, 255)); b0 = 8'($urandom_range(0, 255));
      a1 = 8'($urandom_range(0, 255)); b1 = 8'($urandom_range(0, 255));
      run_op(1'b1, 1'b1, 3'b010, 3'b110, a0, b0, a1, b1, 0);
      mdl_ops++;
      n_checks++; if (obs_id !== 1'(k % 2)) begin n_fail++; $display("FAIL contention_id op=%0d got=%b exp=%0d", k, obs_id, k % 2); end
      n_checks++; if ({obs_rdy0, obs_rdy1} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL contention_ready op=%0d got=%b", k, {obs_rdy0, obs_rdy1}); end
      n_checks++; if (obs_data !== ((k % 2 == 0) ? mdl_sum(a0, b0) : mdl_sum(a1, b1))) begin n_fail++; $display("FAIL contention_data op=%0d got=%h", k, obs_data); end
      mdl_last = k % 2;
    end
  endtask

  task automatic test_backpressure();
    int w;
    w = pick(1'b1, 1'b1, mdl_last);
    run_op(1'b1, 1'b1, 3'b111, 3'b001, 8'h11, 8'h22, 8'h33, 8'h44, 5);
    mdl_last = w; mdl_ops++;
    n_checks++; if (obs_hold_ok !== 1'b1) begin n_fail++; $display("FAIL backpressure_hold got=%b exp=1", obs_hold_ok); end
    n_checks++; if (obs_id !== 1'(w) || obs_data !== ((w == 0) ? 8'h33 : 8'h77)) begin n_fail++; $display("FAIL backpressure_resp got=%b/%h exp=%0d", obs_id, obs_data, w); end
    n_checks++; if ({obs_rv_after, obs_busy_after, obs_busy_after2} !== 3'b000) begin n_fail++; $display("FAIL backpressure_idle got=%b exp=000", {obs_rv_after, obs_busy_after, obs_busy_after2}); end
    n_checks++; if (obs_ops !== 16'(mdl_ops)) begin n_fail++; $display("FAIL backpressure_ops got=%0d exp=%0d", obs_ops, mdl_ops); end
  endtask

  task automatic test_flags();
    run_op(1'b0, 1'b1, 3'b000, 3'b011, 8'h00, 8'h00, 8'hFF, 8'h01, 1);
    mdl_last = 1; mdl_ops++;
    n_checks++; if (obs_data !== 8'h00) begin n_fail++; $display("FAIL flags_data got=%h exp=00", obs_data); end
    n_checks++; if (obs_flags !== 4'b1001) begin n_fail++; $display("FAIL flags_czbits got=%b exp=1001", obs_flags); end
  endtask

  task automatic test_random();
    int r, w;
    bit v0, v1;
    logic [7:0] a0, b0, a1, b1;
    logic [2:0] s0, s1;
    for (int k = 0; k < 20; k++) begin
      r = $urandom_range(1, 3); v0 = r[0]; v1 = r[1];
      a0 = 8'($urandom_range(0, 255)); b0 = 8'($urandom_range(0, 255));
      a1 = 8'($urandom_range(0, 255)); b1 = 8'($urandom_range(0, 255));
      s0 = 3'($urandom_range(0, 7)); s1 = 3'($urandom_range(0, 7));
      w = pick(v0, v1, mdl_last);
      run_op(v0, v1, s0, s1, a0, b0, a1, b1, $urandom_range(0, 3));
      mdl_last = w; mdl_ops++;
      n_checks++; if ({obs_rdy0, obs_rdy1} !== ((w == 0) ? 2'b10 : 2'b01) || obs_id !== 1'(w)) begin n_fail++; $display("FAIL random_grant op=%0d got=%b id=%b exp=%0d", k, {obs_rdy0, obs_rdy1}, obs_id, w); end
      n_checks++; if (obs_selop !== ((w == 0) ? s0 : s1)) begin n_fail++; $display("FAIL random_selop op=%0d got=%b", k, obs_selop); end
      n_checks++; if (obs_data !== ((w == 0) ? mdl_sum(a0, b0) : mdl_sum(a1, b1))) begin n_fail++; $display("FAIL random_data op=%0d got=%h", k, obs_data); end
      n_checks++; if (obs_flags !== ((w == 0) ? mdl_flags(a0, b0) : mdl_flags(a1, b1))) begin n_fail++; $display("FAIL random_flags op=%0d got=%b", k, obs_flags); end
      n_checks++; if (obs_ops !== 16'(mdl_ops) || obs_ops2 !== 2'(mdl_ops % 4)) begin n_fail++; $display("FAIL random_ops op=%0d got=%0d/%0d exp=%0d", k, obs_ops, obs_ops2, mdl_ops); end
      n_checks++; if ({obs_hold_ok, obs_rv_resp, obs_busy_after2} !== 3'b110) begin n_fail++; $display("FAIL random_proto op=%0d got=%b exp=110", k, {obs_hold_ok, obs_rv_resp, obs_busy_after2}); end
    end
  endtask

  task automatic test_reset_midop();
    logic rv_seen;
    req1_valid = 1'b1; req1_a = 8'h40; req1_b = 8'h02; req1_selop = 3'b100;
    step();                       // accept edge
    req1_valid = 1'b0;
    step();                       // now in CAPT
    rst = 1'b0;
    step();
    n_checks++; if ({resp_valid, alu_enaf, busy} !== 3'b000) begin n_fail++; $display("FAIL midop_abort got=%b exp=000", {resp_valid, alu_enaf, busy}); end
    rst = 1'b1;
    rv_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (resp_valid !== 1'b0 || busy !== 1'b0) rv_seen = 1'b1;
    end
    mdl_last = 1; mdl_ops = 0;
    n_checks++; if (rv_seen !== 1'b0 || ops_done !== 16'd0 || w_ops !== 2'd0) begin n_fail++; $display("FAIL midop_silent got=%b/%0d/%0d exp=0/0/0", rv_seen, ops_done, w_ops); end
  endtask

  task automatic test_wrap();
    logic [1:0] exp_seq [5];
    exp_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    for (int k = 0; k < 5; k++) begin
      run_op(1'b1, 1'b0, 3'b001, 3'b000, 8'(k), 8'h05, 8'h00, 8'h00, 0);
      mdl_last = 0; mdl_ops++;
      n_checks++; if (obs_ops2 !== exp_seq[k]) begin n_fail++; $display("FAIL wrap_ops2 op=%0d got=%0d exp=%0d", k, obs_ops2, exp_seq[k]); end
      n_checks++; if (obs_ops !== 16'(k + 1)) begin n_fail++; $display("FAIL wrap_ops16 op=%0d got=%0d exp=%0d", k, obs_ops, k + 1); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_flags();
    test_random();
    test_reset_midop();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

endmodule
